// File: rtl/duty_sched_if.sv
// Configuration channel for duty_sched: a valid/ready handshake that carries
// one waveform job (low length, high length, repeat count).
interface duty_sched_if #(
   parameter int CW = 8,
   parameter int NW = 8
);

   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_low;
   logic [CW-1:0] cfg_high;
   logic [NW-1:0] cfg_reps;

   // The job source drives the fields and valid, and watches ready
   modport master (
      output cfg_valid,
      output cfg_low,
      output cfg_high,
      output cfg_reps,
      input  cfg_ready
   );

   // The scheduler consumes the job and reports when it can take one
   modport slave (
      input  cfg_valid,
      input  cfg_low,
      input  cfg_high,
      input  cfg_reps,
      output cfg_ready
   );

endinterface

// File: rtl/duty_sched.sv
// Duty-cycle waveform scheduler.
// A job describes a period of 'low' cycles at a=0 followed by 'high' cycles
// at a=1, repeated 'reps' times (0 = forever). The job fields are captured
// when the job is accepted, so the source may change them freely afterwards.
// All outputs are registered and are derived from the next state, so each
// output always reflects the state the FSM is currently in.
module duty_sched #(
   parameter int CW = 8,
   parameter int NW = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   duty_sched_if.slave cfg,
   input  logic        abort,
   output logic        a,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } stateType;

   stateType      state;
   stateType      stateNext;

   logic [CW-1:0] phaseCnt;
   logic [CW-1:0] phaseCntNext;
   logic [CW-1:0] lowLen;
   logic [CW-1:0] lowLenNext;
   logic [CW-1:0] highLen;
   logic [CW-1:0] highLenNext;
   logic [NW-1:0] repCnt;
   logic [NW-1:0] repCntNext;
   logic [NW-1:0] repTarget;
   logic [NW-1:0] repTargetNext;

   logic          readyReg;
   logic          accept;
   logic          periodEnd;

   // readyReg is only set by a clock edge, so ready stays low while reset is
   // held and rises on the first edge after release; abort masks it at once
   assign cfg.cfg_ready = readyReg & ~abort;
   assign accept        = cfg.cfg_valid & cfg.cfg_ready;

   // State, counters and latched job fields; outputs registered from next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         phaseCnt  <= '0;
         lowLen    <= '0;
         highLen   <= '0;
         repCnt    <= '0;
         repTarget <= '0;
         readyReg  <= 1'b0;
         a         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= stateNext;
         phaseCnt  <= phaseCntNext;
         lowLen    <= lowLenNext;
         highLen   <= highLenNext;
         repCnt    <= repCntNext;
         repTarget <= repTargetNext;
         readyReg  <= (stateNext == IDLE);
         a         <= (stateNext == HIGH);
         busy      <= (stateNext == LOW) || (stateNext == HIGH);
         done      <= (stateNext == DONE);
      end
   end

   // Next-state logic: phase counter is a down-counter loaded with the phase
   // length, and a phase ends on the cycle it reads 1. At a period end the
   // repeat counter advances and either finishes the job or restarts the
   // period with no gap cycle. Abort overrides everything outside IDLE.
   always_comb begin
      stateNext     = state;
      phaseCntNext  = phaseCnt;
      lowLenNext    = lowLen;
      highLenNext   = highLen;
      repCntNext    = repCnt;
      repTargetNext = repTarget;
      periodEnd     = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               lowLenNext    = cfg.cfg_low;
               highLenNext   = cfg.cfg_high;
               repTargetNext = cfg.cfg_reps;
               repCntNext    = '0;
               if (cfg.cfg_low != '0) begin
                  stateNext    = LOW;
                  phaseCntNext = cfg.cfg_low;
               end else if (cfg.cfg_high != '0) begin
                  stateNext    = HIGH;
                  phaseCntNext = cfg.cfg_high;
               end else begin
                  stateNext    = DONE;
                  phaseCntNext = '0;
               end
            end
         end

         LOW: begin
            if (phaseCnt <= CW'(1)) begin
               if (highLen != '0) begin
                  stateNext    = HIGH;
                  phaseCntNext = highLen;
               end else begin
                  periodEnd = 1'b1;
               end
            end else begin
               phaseCntNext = phaseCnt - CW'(1);
            end
         end

         HIGH: begin
            if (phaseCnt <= CW'(1)) begin
               periodEnd = 1'b1;
            end else begin
               phaseCntNext = phaseCnt - CW'(1);
            end
         end

         DONE: begin
            stateNext = IDLE;
         end

         default: begin
            stateNext = IDLE;
         end
      endcase

      if (periodEnd) begin
         repCntNext = repCnt + NW'(1);
         if ((repTarget != '0) && (repCntNext == repTarget)) begin
            stateNext    = DONE;
            phaseCntNext = '0;
         end else if (lowLen != '0) begin
            stateNext    = LOW;
            phaseCntNext = lowLen;
         end else begin
            stateNext    = HIGH;
            phaseCntNext = highLen;
         end
      end

      if (abort && (state != IDLE)) begin
         stateNext    = IDLE;
         phaseCntNext = '0;
         repCntNext   = '0;
      end
   end

endmodule

// File: tb/tb_duty_sched.sv
// Directed testbench for duty_sched. Each task drives one scenario and
// compares the DUT outputs against hand-computed cycle-by-cycle values.
// Inputs change and outputs are sampled 1 ns after the rising clock edge.
module tb_duty_sched;

   logic clk;
   logic rst_n;
   logic abort;
   logic a;
   logic busy;
   logic done;

   int nChecks;
   int nFails;

   duty_sched_if #(.CW(8), .NW(8)) cfgIf ();

   duty_sched #(.CW(8), .NW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cfg   (cfgIf),
      .abort (abort),
      .a     (a),
      .busy  (busy),
      .done  (done)
   );

   // 20 ns clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_job(input int low, input int high, input int reps);
      cfgIf.cfg_low   = 8'(low);
      cfgIf.cfg_high  = 8'(high);
      cfgIf.cfg_reps  = 8'(reps);
      cfgIf.cfg_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #3;
      nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL reset_a: got %b expected 0", a); end
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      nChecks++; if (cfgIf.cfg_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ready: got %b expected 0", cfgIf.cfg_ready); end
      tick();
      nChecks++; if (cfgIf.cfg_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ready_held: got %b expected 0", cfgIf.cfg_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      nChecks++; if (cfgIf.cfg_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ready_preedge: got %b expected 0", cfgIf.cfg_ready); end
      tick();
      nChecks++; if (cfgIf.cfg_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_ready_first_edge: got %b expected 1", cfgIf.cfg_ready); end
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_basic();
      bit [1:10] expA;
      expA = 10'b0000100001;
      drive_job(4, 1, 2);
      nChecks++; if (cfgIf.cfg_ready !== 1'b1) begin nFails++; $display("[TB] FAIL basic_ready: got %b expected 1", cfgIf.cfg_ready); end
      tick();
      cfgIf.cfg_valid = 1'b0;
      cfgIf.cfg_low   = 8'd7;
      cfgIf.cfg_high  = 8'd7;
      cfgIf.cfg_reps  = 8'd7;
      for (int k = 1; k <= 10; k++) begin
         nChecks++; if (a !== expA[k]) begin nFails++; $display("[TB] FAIL basic_a cycle %0d: got %b expected %b", k, a, expA[k]); end
         nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL basic_busy cycle %0d: got %b expected 1", k, busy); end
         nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL basic_done cycle %0d: got %b expected 0", k, done); end
         tick();
      end
      nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL basic_done_c11: got %b expected 1", done); end
      nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL basic_a_c11: got %b expected 0", a); end
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL basic_busy_c11: got %b expected 0", busy); end
      nChecks++; if (cfgIf.cfg_ready !== 1'b0) begin nFails++; $display("[TB] FAIL basic_ready_c11: got %b expected 0", cfgIf.cfg_ready); end
      tick();
      nChecks++; if (cfgIf.cfg_ready !== 1'b1) begin nFails++; $display("[TB] FAIL basic_ready_c12: got %b expected 1", cfgIf.cfg_ready); end
      nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL basic_done_c12: got %b expected 0", done); end
   endtask

   task automatic test_zero_phase();
      // low=0, high=3, reps=1
      drive_job(0, 3, 1);
      tick();
      cfgIf.cfg_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         nChecks++; if (a !== 1'b1) begin nFails++; $display("[TB] FAIL zlow_a cycle %0d: got %b expected 1", k, a); end
         nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL zlow_busy cycle %0d: got %b expected 1", k, busy); end
         tick();
      end
      nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL zlow_done_c4: got %b expected 1", done); end
      nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL zlow_a_c4: got %b expected 0", a); end
      tick();
      // low=0, high=0, reps=5
      drive_job(0, 0, 5);
      tick();
      cfgIf.cfg_valid = 1'b0;
      nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL zboth_done_c1: got %b expected 1", done); end
      nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL zboth_a_c1: got %b expected 0", a); end
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL zboth_busy_c1: got %b expected 0", busy); end
      tick();
      nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL zboth_done_c2: got %b expected 0", done); end
      nChecks++; if (cfgIf.cfg_ready !== 1'b1) begin nFails++; $display("[TB] FAIL zboth_ready_c2: got %b expected 1", cfgIf.cfg_ready); end
      // low=1, high=0, reps=3
      drive_job(1, 0, 3);
      tick();
      cfgIf.cfg_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL zhigh_a cycle %0d: got %b expected 0", k, a); end
         nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL zhigh_busy cycle %0d: got %b expected 1", k, busy); end
         nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL zhigh_done cycle %0d: got %b expected 0", k, done); end
         tick();
      end
      nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL zhigh_done_c4: got %b expected 1", done); end
      tick();
   endtask

   task automatic test_abort();
      bit [1:8] expA;
      int donesSeen;
      expA = 8'b00110011;
      donesSeen = 0;
      drive_job(2, 2, 0);
      tick();
      cfgIf.cfg_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         nChecks++; if (a !== expA[k]) begin nFails++; $display("[TB] FAIL abort_a cycle %0d: got %b expected %b", k, a, expA[k]); end
         if (done !== 1'b0) donesSeen++;
         tick();
      end
      abort = 1'b1;
      nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL abort_a_c9: got %b expected 0", a); end
      nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL abort_busy_c9: got %b expected 1", busy); end
      tick();
      abort = 1'b0;
      #1;
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL abort_busy_c10: got %b expected 0", busy); end
      nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL abort_a_c10: got %b expected 0", a); end
      nChecks++; if (cfgIf.cfg_ready !== 1'b1) begin nFails++; $display("[TB] FAIL abort_ready_c10: got %b expected 1", cfgIf.cfg_ready); end
      if (done !== 1'b0) donesSeen++;
      tick();
      if (done !== 1'b0) donesSeen++;
      nChecks++; if (donesSeen != 0) begin nFails++; $display("[TB] FAIL abort_no_done: got %0d done cycles expected 0", donesSeen); end
   endtask

   task automatic test_back_to_back();
      drive_job(2, 3, 1);
      tick();
      for (int k = 1; k <= 5; k++) begin
         drive_job(k + 4, k, 0);
         nChecks++; if (a !== (k >= 3)) begin nFails++; $display("[TB] FAIL hold_a cycle %0d: got %b expected %b", k, a, (k >= 3)); end
         nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL hold_busy cycle %0d: got %b expected 1", k, busy); end
         nChecks++; if (cfgIf.cfg_ready !== 1'b0) begin nFails++; $display("[TB] FAIL hold_ready cycle %0d: got %b expected 0", k, cfgIf.cfg_ready); end
         tick();
      end
      drive_job(1, 1, 1);
      nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL hold_done_c6: got %b expected 1", done); end
      nChecks++; if (cfgIf.cfg_ready !== 1'b0) begin nFails++; $display("[TB] FAIL hold_ready_c6: got %b expected 0", cfgIf.cfg_ready); end
      tick();
      nChecks++; if (cfgIf.cfg_ready !== 1'b1) begin nFails++; $display("[TB] FAIL hold_ready_c7: got %b expected 1", cfgIf.cfg_ready); end
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL hold_busy_c7: got %b expected 0", busy); end
      tick();
      cfgIf.cfg_valid = 1'b0;
      nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL next_busy_c1: got %b expected 1", busy); end
      nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL next_a_c1: got %b expected 0", a); end
      tick();
      nChecks++; if (a !== 1'b1) begin nFails++; $display("[TB] FAIL next_a_c2: got %b expected 1", a); end
      tick();
      nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL next_done_c3: got %b expected 1", done); end
      tick();
   endtask

   task automatic test_max_phase();
      int bad;
      bad = 0;
      drive_job(255, 1, 1);
      tick();
      cfgIf.cfg_valid = 1'b0;
      for (int k = 1; k <= 255; k++) begin
         if (a !== 1'b0 || busy !== 1'b1) bad++;
         tick();
      end
      nChecks++; if (bad != 0) begin nFails++; $display("[TB] FAIL max_low_cycles: got %0d bad cycles expected 0", bad); end
      nChecks++; if (a !== 1'b1) begin nFails++; $display("[TB] FAIL max_a_c256: got %b expected 1", a); end
      tick();
      nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL max_done_c257: got %b expected 1", done); end
      tick();
   endtask

   task automatic test_continuous();
      int bad;
      bad = 0;
      drive_job(0, 1, 0);
      tick();
      cfgIf.cfg_valid = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         if (a !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
         tick();
      end
      nChecks++; if (bad != 0) begin nFails++; $display("[TB] FAIL cont_wrap: got %0d bad cycles expected 0", bad); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL cont_abort_busy: got %b expected 0", busy); end
      nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL cont_abort_a: got %b expected 0", a); end
      nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL cont_abort_done: got %b expected 0", done); end
   endtask

   task automatic test_reset_mid();
      drive_job(1, 5, 1);
      tick();
      cfgIf.cfg_valid = 1'b0;
      tick();
      nChecks++; if (a !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_a_high: got %b expected 1", a); end
      #3 rst_n = 1'b0;
      #1;
      nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_async_a: got %b expected 0", a); end
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_async_busy: got %b expected 0", busy); end
      nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_async_done: got %b expected 0", done); end
      nChecks++; if (cfgIf.cfg_ready !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_async_ready: got %b expected 0", cfgIf.cfg_ready); end
      #1 rst_n = 1'b1;
      drive_job(1, 1, 1);
      tick();
      nChecks++; if (cfgIf.cfg_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_ready_first_edge: got %b expected 1", cfgIf.cfg_ready); end
      nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_no_done: got %b expected 0", done); end
      tick();
      cfgIf.cfg_valid = 1'b0;
      nChecks++; if (busy !== 1'b1 || a !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_job_c1: got busy=%b a=%b expected busy=1 a=0", busy, a); end
      tick();
      nChecks++; if (a !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_job_c2: got a=%b expected 1", a); end
      tick();
      nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_job_c3: got done=%b expected 1", done); end
      tick();
   endtask

   task automatic test_abort_idle();
      abort = 1'b1;
      drive_job(1, 1, 1);
      #1;
      nChecks++; if (cfgIf.cfg_ready !== 1'b0) begin nFails++; $display("[TB] FAIL aidle_ready: got %b expected 0", cfgIf.cfg_ready); end
      tick();
      abort = 1'b0;
      cfgIf.cfg_valid = 1'b0;
      #1;
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL aidle_not_accepted: got busy=%b expected 0", busy); end
      nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL aidle_done: got %b expected 0", done); end
      nChecks++; if (cfgIf.cfg_ready !== 1'b1) begin nFails++; $display("[TB] FAIL aidle_ready_after: got %b expected 1", cfgIf.cfg_ready); end
   endtask

   initial begin
      nChecks         = 0;
      nFails          = 0;
      abort           = 1'b0;
      cfgIf.cfg_valid = 1'b0;
      cfgIf.cfg_low   = '0;
      cfgIf.cfg_high  = '0;
      cfgIf.cfg_reps  = '0;
      $display("[TB] starting duty_sched tests");
      test_reset();
      test_basic();
      test_zero_phase();
      test_abort();
      test_back_to_back();
      test_max_phase();
      test_continuous();
      test_reset_mid();
      test_abort_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/duty_sched.md
DUTY_SCHED -- requirements
Module: duty_sched

Interface
REQ-001 Parameter CW, default 8: width of the phase-length fields and the phase counter.
REQ-002 Parameter NW, default 8: width of the repeat-count field and the repeat counter.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port cfg_valid, input, 1: a waveform job is offered.
REQ-006 Port cfg_ready, output, 1: the block can accept a job.
REQ-007 Port cfg_low, input, CW: length of the low phase, in clk cycles.
REQ-008 Port cfg_high, input, CW: length of the high phase, in clk cycles.
REQ-009 Port cfg_reps, input, NW: number of low+high periods; 0 means run continuously.
REQ-010 Port abort, input, 1: terminate the active job.
REQ-011 Port a, output, 1: generated waveform, registered.
REQ-012 Port busy, output, 1: a job is active (LOW or HIGH state).
REQ-013 Port done, output, 1: one-cycle pulse on normal job completion.

Function
REQ-014 The block SHALL implement FSM states IDLE, LOW, HIGH and DONE.
REQ-015 cfg_ready SHALL be 1 only in IDLE with abort=0.
REQ-016 A job SHALL be accepted on the edge where cfg_valid=1 and cfg_ready=1.
REQ-017 On acceptance, cfg_low, cfg_high and cfg_reps SHALL be latched; later input changes have no effect on the running job.
REQ-018 If the latched low>0, the FSM SHALL enter LOW on the accepting edge, so a=0 from the first cycle after acceptance.
REQ-019 If low=0 and high>0, the FSM SHALL enter HIGH directly from acceptance.
REQ-020 If low=0 and high=0, the FSM SHALL enter DONE directly; a stays 0.
REQ-021 LOW SHALL last exactly low cycles with a=0, then transition to HIGH; if high=0, the period ends instead.
REQ-022 HIGH SHALL last exactly high cycles with a=1, then the period ends.
REQ-023 At each period end, the repeat counter SHALL increment.
REQ-024 At period end, if reps≠0 and the completed-period count equals reps, the FSM SHALL go to DONE; otherwise it starts the next period (LOW, or HIGH if low=0) with no gap cycle.
REQ-025 For reps=0, the block SHALL run until abort; the repeat counter wraps modulo 2^NW without effect.
REQ-026 DONE SHALL last one cycle with done=1 and a=0, then return to IDLE.
REQ-027 A new job SHALL NOT be accepted in DONE.
REQ-028 abort=1 in LOW, HIGH or DONE SHALL force IDLE at the next edge with a=0 and busy=0; done is not asserted for an aborted job.
REQ-029 abort has priority over period-end and DONE transitions in the same cycle.
REQ-030 abort in IDLE SHALL be ignored, and no job is accepted that cycle.
REQ-031 The phase counter SHALL count in CW bits with no overflow; maximum phase length is 2^CW−1.
REQ-032 busy SHALL be 1 exactly in LOW and HIGH.

Reset
REQ-033 rst_n=0 SHALL immediately (asynchronously) force: IDLE, a=0, busy=0, done=0, cfg_ready=0 while held, all counters and latched fields 0.
REQ-034 After rst_n deasserts, cfg_ready SHALL be 1 from the first edge (IDLE, abort=0).
REQ-035 Reset during an active job SHALL discard the job; no done is issued.

Verification
REQ-036 Accept low=4, high=1, reps=2 -> a = 0,0,0,0,1,0,0,0,0,1 in cycles 1-10 after acceptance; done=1 in cycle 11; cfg_ready=1 in cycle 12. This gives 80/20 ns at a 20 ns clk.
REQ-037 low=0, high=3, reps=1 -> a=1 in cycles 1-3; done in cycle 4. Also low=0, high=0, reps=5 -> done in cycle 1, a never 1.
REQ-038 low=2, high=2, reps=0; abort in cycle 9 -> a = 0,0,1,1,0,0,1,1 through cycle 8, then IDLE with a=0, no done pulse.
REQ-039 cfg_valid held high with changing fields while busy -> no second acceptance; waveform follows the latched values only; the next job is accepted in the first IDLE cycle after done.
REQ-040 rst_n pulsed low mid-HIGH -> a, busy and done go to 0 without a clock edge; after release, an immediate job low=1, high=1, reps=1 completes normally (done in cycle 3).
REQ-041 cfg_valid=1 with abort=1 in IDLE -> not accepted; cfg_ready=0 that cycle.
